pifo_sched: RTL and testbench

Single-clock, parametrised push-in-first-out scheduler that stores descriptors inline in a sorted register array. It serves NUM_IN push ports through a round-robin arbiter and pops the lowest-priority-value entry. Threshold drop and full-array tail eviction report victims on a dedicated drop port. It replaces the separate PIFO, descriptor buffer and allocator combination in designs that need several producers and no clock-domain crossing.

---
 rtl/pifo_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_pifo_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_sched.sv
// pifo_sched -- push-in-first-out scheduler with inline descriptor storage.
//
// Entries live in a register array kept sorted by ascending priority value
// (ties keep arrival order). Several producers share one insert path through
// a round-robin arbiter. Each cycle at most one candidate is resolved: it is
// inserted, discarded by the occupancy threshold, or inserted while evicting
// the resident tail. Discarded and evicted items are reported on the drop
// port one cycle later.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready         per-port push handshake (NUM_IN bits each)
//   s_prio, s_data          packed per-port priority / descriptor
//   s_drop_en               per-port permission for threshold discard
//   m_valid/m_ready         head handshake; m_prio/m_data come from slot 0
//   drop_valid              one-cycle drop report, no backpressure
//   drop_prio, drop_data    dropped item
//   drop_evict              1 = resident tail evicted, 0 = incoming discarded
//   count                   current occupancy
//   drop_cnt                saturating total of drop reports
module pifo_sched #(
    parameter int DEPTH       = 16,
    parameter int NUM_IN      = 2,
    parameter int BITPRIO     = 16,
    parameter int BITDESC     = 32,
    parameter int DROP_THRESH = DEPTH - 4,
    parameter int BITCNT      = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          s_valid,
    output logic [NUM_IN-1:0]          s_ready,
    input  logic [NUM_IN*BITPRIO-1:0]  s_prio,
    input  logic [NUM_IN*BITDESC-1:0]  s_data,
    input  logic [NUM_IN-1:0]          s_drop_en,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [BITPRIO-1:0]         m_prio,
    output logic [BITDESC-1:0]         m_data,
    output logic                       drop_valid,
    output logic [BITPRIO-1:0]         drop_prio,
    output logic [BITDESC-1:0]         drop_data,
    output logic                       drop_evict,
    output logic [BITCNT-1:0]          count,
    output logic [31:0]                drop_cnt
);

    localparam int RRW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {
        ACT_NONE,    // no candidate, or candidate back-pressured
        ACT_DROP,    // candidate discarded by the threshold rule
        ACT_INSERT,  // candidate inserted into free space
        ACT_EVICT    // candidate inserted, resident tail pushed out
    } act_e;

    logic [BITPRIO-1:0] slot_prio [DEPTH];
    logic [BITDESC-1:0] slot_data [DEPTH];
    logic [RRW-1:0]     rr;

    logic               pop;
    logic [BITCNT-1:0]  eff;
    act_e               act;

    logic               cand_found;
    logic [RRW-1:0]     cand_idx;
    logic [BITPRIO-1:0] cand_prio;
    logic [BITDESC-1:0] cand_data;
    logic               cand_drop_en;

    logic [BITPRIO-1:0] sh_prio  [DEPTH];
    logic [BITDESC-1:0] sh_data  [DEPTH];
    logic [BITPRIO-1:0] nxt_prio [DEPTH];
    logic [BITDESC-1:0] nxt_data [DEPTH];
    logic [BITCNT-1:0]  ins_pos;
    logic [BITCNT-1:0]  nxt_count;

    assign m_valid = (count != '0);
    assign m_prio  = slot_prio[0];
    assign m_data  = slot_data[0];
    assign pop     = m_valid && m_ready;
    assign eff     = count - BITCNT'(pop);

    // Round-robin candidate: first requesting port at or above rr, else the
    // first requesting port below rr (the wrap-around part of the search).
    always_comb begin
        // NOTE: every variable gets a default before any condition so that no
        // path leaves it unassigned and synthesis cannot infer a latch.
        cand_found   = 1'b0;
        cand_idx     = '0;
        cand_prio    = '0;
        cand_data    = '0;
        cand_drop_en = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!cand_found && s_valid[i] && (RRW'(i) >= rr)) begin
                cand_found   = 1'b1;
                cand_idx     = RRW'(i);
                cand_prio    = s_prio[i*BITPRIO +: BITPRIO];
                cand_data    = s_data[i*BITDESC +: BITDESC];
                cand_drop_en = s_drop_en[i];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!cand_found && s_valid[i] && (RRW'(i) < rr)) begin
                cand_found   = 1'b1;
                cand_idx     = RRW'(i);
                cand_prio    = s_prio[i*BITPRIO +: BITPRIO];
                cand_data    = s_data[i*BITDESC +: BITDESC];
                cand_drop_en = s_drop_en[i];
            end
        end
    end

    // Array after this cycle's pop. Vacated top slot is zero-filled so that
    // every slot at or beyond count always holds zero.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            sh_prio[i] = pop ? slot_prio[i+1] : slot_prio[i];
            sh_data[i] = pop ? slot_data[i+1] : slot_data[i];
        end
        sh_prio[DEPTH-1] = pop ? '0 : slot_prio[DEPTH-1];
        sh_data[DEPTH-1] = pop ? '0 : slot_data[DEPTH-1];
    end

    // Resolve the candidate against the post-pop occupancy. Eviction is only
    // reachable with eff == DEPTH, i.e. no pop, so sh_* equals the stored tail.
    always_comb begin
        act = ACT_NONE;
        if (cand_found) begin
            if (cand_drop_en && (int'(eff) >= DROP_THRESH)) begin
                act = ACT_DROP;
            end else if (int'(eff) < DEPTH) begin
                act = ACT_INSERT;
            end else if (sh_prio[DEPTH-1] > cand_prio) begin
                act = ACT_EVICT;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            s_ready[i] = (act != ACT_NONE) && (cand_idx == RRW'(i));
        end
    end

    // Insert position = number of live entries with prio <= new prio, which
    // places the new item behind all equal priorities. On eviction the tail
    // has prio > new, so it never counts and simply falls off the top.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((BITCNT'(i) < eff) && (sh_prio[i] <= cand_prio)) begin
                ins_pos = ins_pos + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_prio[i] = sh_prio[i];
            nxt_data[i] = sh_data[i];
        end
        if ((act == ACT_INSERT) || (act == ACT_EVICT)) begin
            if (ins_pos == '0) begin
                nxt_prio[0] = cand_prio;
                nxt_data[0] = cand_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (BITCNT'(i) == ins_pos) begin
                    nxt_prio[i] = cand_prio;
                    nxt_data[i] = cand_data;
                end else if (BITCNT'(i) > ins_pos) begin
                    nxt_prio[i] = sh_prio[i-1];
                    nxt_data[i] = sh_data[i-1];
                end
            end
        end
    end

    always_comb begin
        nxt_count = count;
        if ((act == ACT_INSERT) && !pop) begin
            nxt_count = count + 1'b1;
        end else if ((act != ACT_INSERT) && pop) begin
            nxt_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot array is reset explicitly because m_prio/m_data
            // are read straight from slot 0 and must come out of reset as 0.
            for (int i = 0; i < DEPTH; i++) begin
                slot_prio[i] <= '0;
                slot_data[i] <= '0;
            end
            count      <= '0;
            rr         <= '0;
            drop_valid <= 1'b0;
            drop_prio  <= '0;
            drop_data  <= '0;
            drop_evict <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so update order inside this block is irrelevant.
            for (int i = 0; i < DEPTH; i++) begin
                slot_prio[i] <= nxt_prio[i];
                slot_data[i] <= nxt_data[i];
            end
            count <= nxt_count;
            if (act != ACT_NONE) begin
                rr <= (cand_idx == RRW'(NUM_IN - 1)) ? '0 : cand_idx + 1'b1;
            end
            drop_valid <= (act == ACT_DROP) || (act == ACT_EVICT);
            if (act == ACT_DROP) begin
                drop_prio  <= cand_prio;
                drop_data  <= cand_data;
                drop_evict <= 1'b0;
            end else if (act == ACT_EVICT) begin
                drop_prio  <= sh_prio[DEPTH-1];
                drop_data  <= sh_data[DEPTH-1];
                drop_evict <= 1'b1;
            end
            if (((act == ACT_DROP) || (act == ACT_EVICT)) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pifo_sched.sv
// Self-checking bench for pifo_sched. A queue-based reference model applies
// the scheduling rules (sorted insert behind equal priorities, threshold drop,
// tail eviction, round-robin grant) and every cycle is compared against it;
// directed steps cover the ordering, arbitration, drop, eviction and reset
// scenarios, followed by a randomized run with alternating fill/drain bias.
module tb_pifo_sched;

    localparam int DEPTH   = 16;
    localparam int NUM_IN  = 2;
    localparam int BITPRIO = 16;
    localparam int BITDESC = 32;
    localparam int THRESH  = DEPTH - 4;
    localparam int BITCNT  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [BITPRIO-1:0] prio;
        logic [BITDESC-1:0] data;
    } ent_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_IN-1:0]         s_valid = '0;
    logic [NUM_IN-1:0]         s_ready;
    logic [NUM_IN*BITPRIO-1:0] s_prio = '0;
    logic [NUM_IN*BITDESC-1:0] s_data = '0;
    logic [NUM_IN-1:0]         s_drop_en = '0;
    logic                      m_valid;
    logic                      m_ready = 1'b0;
    logic [BITPRIO-1:0]        m_prio;
    logic [BITDESC-1:0]        m_data;
    logic                      drop_valid;
    logic [BITPRIO-1:0]        drop_prio;
    logic [BITDESC-1:0]        drop_data;
    logic                      drop_evict;
    logic [BITCNT-1:0]         count;
    logic [31:0]               drop_cnt;

    pifo_sched #(
        .DEPTH(DEPTH), .NUM_IN(NUM_IN), .BITPRIO(BITPRIO), .BITDESC(BITDESC),
        .DROP_THRESH(THRESH), .BITCNT(BITCNT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_prio(s_prio), .s_data(s_data),
        .s_drop_en(s_drop_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_prio(m_prio), .m_data(m_data),
        .drop_valid(drop_valid), .drop_prio(drop_prio), .drop_data(drop_data),
        .drop_evict(drop_evict), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    ent_t        q[$];
    int          m_rr = 0;
    logic [31:0] m_drop_cnt = '0;
    logic [NUM_IN-1:0] obs_ready = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        s_valid   = '0;
        s_drop_en = '0;
        s_prio    = '0;
        s_data    = '0;
    endtask

    task automatic set_port(input int port, input int prio, input logic [31:0] data,
                            input logic drop_en);
        s_valid[port]                      = 1'b1;
        s_prio[port*BITPRIO +: BITPRIO]    = BITPRIO'(prio);
        s_data[port*BITDESC +: BITDESC]    = data;
        s_drop_en[port]                    = drop_en;
    endtask

    task automatic push0(input int prio, input logic [31:0] data, input logic drop_en);
        clear_in();
        set_port(0, prio, data, drop_en);
    endtask

    // One clock: model decides from the current inputs, s_ready is compared
    // before the edge, and the post-edge outputs are compared against the
    // updated model. Called at edge+1, returns at the next edge+1.
    task automatic cycle();
        logic              pop;
        int                eff;
        int                cand;
        int                p;
        int                j;
        logic              thr, ins, ev;
        logic              exp_dv;
        logic              exp_evict;
        ent_t              nw;
        ent_t              dropped;
        logic [NUM_IN-1:0] exp_ready;

        #1;
        pop  = (q.size() != 0) && m_ready;
        eff  = q.size() - (pop ? 1 : 0);
        cand = -1;
        for (int k = 0; k < NUM_IN; k++) begin
            p = (m_rr + k) % NUM_IN;
            if (cand < 0 && s_valid[p]) cand = p;
        end
        thr = 1'b0; ins = 1'b0; ev = 1'b0;
        nw  = '0;
        exp_ready = '0;
        if (cand >= 0) begin
            nw.prio = s_prio[cand*BITPRIO +: BITPRIO];
            nw.data = s_data[cand*BITDESC +: BITDESC];
            thr = s_drop_en[cand] && (eff >= THRESH);
            ins = !thr && (eff < DEPTH);
            ev  = !thr && (eff == DEPTH) && (q[$].prio > nw.prio);
            if (thr || ins || ev) exp_ready[cand] = 1'b1;
        end
        obs_ready = s_ready;
        check("s_ready", 64'(s_ready), 64'(exp_ready));

        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        exp_dv    = 1'b0;
        exp_evict = 1'b0;
        dropped   = '0;
        if (thr) begin
            exp_dv  = 1'b1;
            dropped = nw;
        end else if (ins || ev) begin
            if (ev) begin
                dropped   = q.pop_back();
                exp_dv    = 1'b1;
                exp_evict = 1'b1;
            end
            j = q.size();
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].prio > nw.prio) j = i;
            end
            q.insert(j, nw);
        end
        if (thr || ins || ev) m_rr = (cand + 1) % NUM_IN;
        if (exp_dv && m_drop_cnt != 32'hffff_ffff) m_drop_cnt = m_drop_cnt + 1;

        check("count", 64'(count), 64'(q.size()));
        check("m_valid", 64'(m_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("m_prio", 64'(m_prio), 64'(q[0].prio));
            check("m_data", 64'(m_data), 64'(q[0].data));
        end
        check("drop_valid", 64'(drop_valid), 64'(exp_dv));
        if (exp_dv) begin
            check("drop_prio", 64'(drop_prio), 64'(dropped.prio));
            check("drop_data", 64'(drop_data), 64'(dropped.data));
            check("drop_evict", 64'(drop_evict), 64'(exp_evict));
        end
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop_cnt));
    endtask

    // Asserts reset at the current time (away from a clock edge), checks that
    // every output is cleared before the next edge, then releases it.
    task automatic apply_reset();
        clear_in();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_prio", 64'(m_prio), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_drop_valid", 64'(drop_valid), 64'(0));
        check("rst_drop_evict", 64'(drop_evict), 64'(0));
        check("rst_drop_prio", 64'(drop_prio), 64'(0));
        check("rst_drop_data", 64'(drop_data), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        q.delete();
        m_rr       = 0;
        m_drop_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int          ord_prio [4] = '{5, 3, 5, 1};
    logic [31:0] ord_data [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    int          exp_prio [4] = '{1, 3, 5, 5};
    logic [31:0] exp_data [4] = '{32'hD, 32'hB, 32'hA, 32'hC};

    initial begin
        #3;
        apply_reset();

        // Ordering and ties.
        for (int i = 0; i < 4; i++) begin
            push0(ord_prio[i], ord_data[i], 1'b0);
            cycle();
        end
        clear_in();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ord_head_prio", 64'(m_prio), 64'(exp_prio[i]));
            check("ord_head_data", 64'(m_data), 64'(exp_data[i]));
            check("ord_count", 64'(count), 64'(4 - i));
            cycle();
        end
        check("ord_empty_valid", 64'(m_valid), 64'(0));
        check("ord_empty_count", 64'(count), 64'(0));

        // Round-robin with both ports requesting.
        apply_reset();
        clear_in();
        set_port(0, 40, 32'h1000, 1'b0);
        set_port(1, 41, 32'h2000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_grant", 64'(obs_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        check("rr_count", 64'(count), 64'(4));

        // Threshold drop at occupancy 12.
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            push0((i % 9) + 1, 32'h100 + 32'(i), 1'b0);
            cycle();
        end
        push0(0, 32'hDEAD, 1'b1);
        cycle();
        check("thr_ready", 64'(obs_ready), 64'h1);
        check("thr_drop_valid", 64'(drop_valid), 64'(1));
        check("thr_drop_evict", 64'(drop_evict), 64'(0));
        check("thr_drop_prio", 64'(drop_prio), 64'(0));
        check("thr_count", 64'(count), 64'(12));
        check("thr_drop_cnt", 64'(drop_cnt), 64'(1));

        // Fill to 16 with tail prio 9, then evict with prio 4.
        for (int i = 0; i < 4; i++) begin
            push0(9, 32'h200 + 32'(i), 1'b0);
            cycle();
        end
        check("full_count", 64'(count), 64'(16));
        push0(4, 32'hBEEF, 1'b0);
        cycle();
        check("ev_drop_valid", 64'(drop_valid), 64'(1));
        check("ev_drop_evict", 64'(drop_evict), 64'(1));
        check("ev_drop_prio", 64'(drop_prio), 64'(9));
        check("ev_drop_data", 64'(drop_data), 64'(32'h203));
        check("ev_count", 64'(count), 64'(16));

        // Backpressure until a pop frees a slot.
        push0(20, 32'h2020, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready", 64'(obs_ready), 64'(0));
        end
        m_ready = 1'b1;
        cycle();
        check("bp_release_ready", 64'(obs_ready), 64'h1);
        check("bp_release_count", 64'(count), 64'(16));

        // Full array with simultaneous pop.
        push0(30, 32'h3030, 1'b0);
        cycle();
        check("fp_ready", 64'(obs_ready), 64'h1);
        check("fp_no_drop", 64'(drop_valid), 64'(0));
        check("fp_count", 64'(count), 64'(16));
        check("fp_head_prio", 64'(m_prio), 64'(2));
        check("fp_head_data", 64'(m_data), 64'(32'h101));

        // Reset with a drop pulse pending.
        m_ready = 1'b0;
        push0(50, 32'h5050, 1'b1);
        cycle();
        check("pre_rst_drop_valid", 64'(drop_valid), 64'(1));
        apply_reset();
        push0(7, 32'h77, 1'b0);
        cycle();
        check("post_rst_m_valid", 64'(m_valid), 64'(1));
        check("post_rst_m_prio", 64'(m_prio), 64'(7));
        check("post_rst_m_data", 64'(m_data), 64'(32'h77));
        check("post_rst_count", 64'(count), 64'(1));

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 800; c++) begin
            clear_in();
            for (int p = 0; p < NUM_IN; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    set_port(p, int'($urandom_range(0, 31)), $urandom,
                             ($urandom_range(0, 3) == 0));
                end
            end
            if ((c / 100) % 2 == 0) m_ready = ($urandom_range(0, 3) == 0);
            else                    m_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
